spi_regfile_rw: RTL and testbench
=================================

// Module: spi_regfile_rw
// PURPOSE
//  Parametrised SPI (mode 0/2) peripheral register file. Writes and reads NUM_REGS
//  control registers of DATA_W bits; it is the next generation of the write-only
//  SPI control block that feeds the output-enable/PWM logic. All SPI inputs are
//  oversampled on clk, and all logic runs in the clk domain.
// PARAMETERS
//  NUM_REGS    5  number of registers, 1..2**ADDR_W
//  DATA_W      8  register / data-field width, 1..32
//  ADDR_W      7  address-field width
//  SYNC_STAGES 2  synchroniser depth for sclk/ncs/copi, >=2
//  CPOL        0  sclk idle level: 0 = sample on rising edge, 1 = sample on falling edge
// PORTS
//  clk       in   1                peripheral clock
//  rst       in   1                reset, asynchronous, active-high
//  sclk      in   1                SPI serial clock, async to clk
//  ncs       in   1                SPI chip select, active-low, async to clk
//  copi      in   1                controller out / peripheral in
//  cipo      out  1                peripheral out / controller in, MSB first
//  cipo_oe   out  1                tri-state enable for cipo, 1 while selected
//  regs      out  NUM_REGS*DATA_W  register contents, reg k at [k*DATA_W +: DATA_W]
//  wr_stb    out  1                1-cycle pulse when a register is written
//  wr_addr   out  ADDR_W           address of last committed write; valid with wr_stb
//  addr_err  out  1                1-cycle pulse: frame completed with address >= NUM_REGS
//  frame_err out  1                1-cycle pulse: ncs rose before FRAME_W bits were received
// BEHAVIOUR
//  - Frame, FRAME_W = 1+ADDR_W+DATA_W bits, MSB first: [RW (1=write)][ADDR][DATA].
//  - Sync reset values: sclk chain = CPOL, ncs chain = 1, copi chain = 0.
//    Edge detection compares sync stage N-1 with stage N (extra stage beyond SYNC_STAGES).
//  - Sample edge = leading edge (rise if CPOL=0); shift edge = trailing edge.
//    sclk frequency <= clk/6.
//  - On reset: all regs = 0, cipo = 0, cipo_oe = 0, wr_stb/addr_err/frame_err = 0,
//    wr_addr = 0, FSM = IDLE, bit counter = 0.
//  - FSM:
//    IDLE -> CMD on synced ncs falling.
//    CMD: samples RW + ADDR; -> DATA after 1+ADDR_W samples.
//    DATA: samples DATA_W bits; -> DONE after the last bit.
//    DONE: ignores further sclk edges; -> IDLE on ncs high.
//    Any state -> IDLE on synced ncs high.
//  - Read (RW=0): on the clk after the last address bit, load the shift-out register
//    with regs[ADDR] (0 if ADDR >= NUM_REGS). cipo = shift-out MSB; shift left on
//    each trailing edge in DATA. cipo = 0 outside DATA. Write data bits are ignored.
//  - Write (RW=1): exactly 1 clk after the FRAME_W-th sample:
//    - ADDR < NUM_REGS: regs[ADDR] <= DATA, wr_stb = 1, wr_addr = ADDR.
//    - otherwise: no register change, addr_err = 1 for 1 cycle.
//  - Read with ADDR >= NUM_REGS also pulses addr_err at frame completion.
//  - ncs rising in CMD/DATA (short frame): no write, frame_err pulses 1 cycle,
//    counter cleared. ncs rising in DONE or IDLE: no error.
//  - Bits beyond FRAME_W are ignored; the next frame needs a fresh ncs fall.
//  - cipo_oe = synced ncs low (registered). regs only change on committed writes or reset.
//  - rst asserted mid-frame clears everything; a frame in progress is lost even if ncs stays low.
// TESTING (NUM_REGS=5, DATA_W=8, ADDR_W=7 unless noted)
//  1 write 0x80_A5 (addr 0), then read 0x00_xx
//    -> regs[7:0]=0xA5; wr_stb one pulse with wr_addr=0; cipo shifts 1010_0101.
//  2 write 0x84_3C (addr 4) -> regs[39:32]=0x3C, other regs unchanged;
//    then write 0x85_FF (addr 5) -> addr_err pulse, regs unchanged, no wr_stb.
//  3 write 0x81 + 5 data bits, then ncs high
//    -> frame_err pulse, regs[15:8] still 0, next full frame writes correctly.
//  4 write 0x82_11 followed by 8 extra sclk pulses before ncs high
//    -> regs[23:16]=0x11 only, single wr_stb.
//  5 rst pulse after 10 bits of a write to addr 3 (ncs held low)
//    -> all outputs 0, no write; frame after ncs toggle works.
//  6 CPOL=1, DATA_W=16, NUM_REGS=8: write addr 7=0xBEEF, read back
//    -> cipo returns 0xBEEF, and reading addr 8 returns 0 with addr_err.

Source files
------------

// File: rtl/spi_regfile_rw.sv
// -----------------------------------------------------------------------------
// spi_regfile_rw
//   SPI peripheral register file for SPI modes 0 and 2. The controller sends
//   frames of 1 + ADDR_W + DATA_W bits, MSB first: [RW][ADDR][DATA], where
//   RW = 1 means write. A write commits DATA to regs[ADDR]. A read returns
//   regs[ADDR] on cipo during the data phase. sclk, ncs and copi are
//   oversampled and synchronised into the clk domain, and all state lives
//   in that domain.
//
// Ports
//   clk        peripheral clock
//   rst        asynchronous, active-high reset
//   sclk       SPI clock, asynchronous to clk (at most clk/6)
//   ncs        SPI chip select, active low, asynchronous to clk
//   copi       serial data in
//   cipo       serial data out, MSB first; 0 outside the data phase
//   cipo_oe    tri-state enable for cipo; high while selected (registered)
//   regs       flattened register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_stb     1-cycle pulse when a register is written
//   wr_addr    address of the last committed write
//   addr_err   1-cycle pulse: a complete frame addressed a missing register
//   frame_err  1-cycle pulse: ncs rose before a frame was complete
// -----------------------------------------------------------------------------
module spi_regfile_rw #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       addr_err,
  output logic                       frame_err
);

  localparam int CMD_W = 1 + ADDR_W;
  localparam int MAX_C = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers. sclk and ncs carry one stage beyond the synchroniser
  // so that edges are detected between two already-synchronised samples.
  // copi has the same depth as sclk, so a data bit and its clock edge appear
  // together on the synchronised outputs.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES:0]   sclk_q;
  logic [SYNC_STAGES:0]   ncs_q;
  logic [SYNC_STAGES-1:0] copi_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples its inputs from the same clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= {(SYNC_STAGES + 1){CPOL}};
      ncs_q  <= '1;
      copi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
      ncs_q  <= {ncs_q[SYNC_STAGES-1:0], ncs};
      copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
    end
  end

  logic sclk_s, sclk_p, ncs_s, ncs_p, copi_s;
  logic lead_edge, trail_edge, ncs_fall;

  assign sclk_s     = sclk_q[SYNC_STAGES-1];
  assign sclk_p     = sclk_q[SYNC_STAGES];
  assign ncs_s      = ncs_q[SYNC_STAGES-1];
  assign ncs_p      = ncs_q[SYNC_STAGES];
  assign copi_s     = copi_q[SYNC_STAGES-1];
  // The leading edge moves sclk away from its idle level (CPOL). The
  // trailing edge returns it to idle.
  assign lead_edge  = (sclk_s != sclk_p) && (sclk_s != CPOL);
  assign trail_edge = (sclk_s != sclk_p) && (sclk_s == CPOL);
  assign ncs_fall   = ncs_p && !ncs_s;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   shift_q;
  logic                load_q;
  logic                commit_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                wr_stb_q, addr_err_q, frame_err_q, cipo_oe_q;
  logic [ADDR_W-1:0]   wr_addr_q;

  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic              addr_ok;
  logic [DATA_W-1:0] rd_data_d;

  assign cmd_rw   = cmd_q[CMD_W-1];
  assign cmd_addr = cmd_q[ADDR_W-1:0];
  assign addr_ok  = {1'b0, cmd_addr} < NUM_REGS_L;

  // Read mux. An address that has no register reads as zero.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cmd_addr == ADDR_W'(k)) rd_data_d = regs_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      shift_q     <= '0;
      load_q      <= 1'b0;
      commit_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      addr_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      cipo_oe_q   <= 1'b0;
      // NOTE: the register array is reset explicitly. Reset must leave
      // every control register at zero.
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      wr_stb_q    <= 1'b0;
      addr_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      load_q      <= 1'b0;
      commit_q    <= 1'b0;
      cipo_oe_q   <= !ncs_s;

      // Commit one clk after the final sample. The frame fields are complete
      // by then, and an ncs rise in the same cycle cannot cancel the commit.
      if (commit_q) begin
        if (!addr_ok) begin
          addr_err_q <= 1'b1;
        end else if (cmd_rw) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (cmd_addr == ADDR_W'(k)) regs_q[k] <= data_q;
          end
          wr_stb_q  <= 1'b1;
          wr_addr_q <= cmd_addr;
        end
      end

      if (ncs_s) begin
        if (state_q == S_CMD || state_q == S_DATA) frame_err_q <= 1'b1;
        state_q <= S_IDLE;
        cnt_q   <= '0;
        shift_q <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (ncs_fall) begin
              state_q <= S_CMD;
              cnt_q   <= '0;
            end
          end
          S_CMD: begin
            if (lead_edge) begin
              cmd_q <= (cmd_q << 1) | CMD_W'(copi_s);
              if (cnt_q == CNT_W'(CMD_W - 1)) begin
                state_q <= S_DATA;
                cnt_q   <= '0;
                load_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          S_DATA: begin
            if (load_q) begin
              shift_q <= cmd_rw ? '0 : rd_data_d;
            end else if (lead_edge) begin
              data_q <= (data_q << 1) | DATA_W'(copi_s);
              if (cnt_q == CNT_W'(DATA_W - 1)) begin
                state_q  <= S_DONE;
                cnt_q    <= '0;
                commit_q <= 1'b1;
                shift_q  <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else if (trail_edge && cnt_q != '0) begin
              // The trailing edge right after the last address bit does not
              // shift. The MSB was loaded there and has not been sampled yet.
              shift_q <= shift_q << 1;
            end
          end
          S_DONE: begin
            // Extra sclk edges are ignored until ncs goes high.
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // shift_q is zero outside the data phase, so cipo is low there too.
  assign cipo      = shift_q[DATA_W-1];
  assign cipo_oe   = cipo_oe_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign addr_err  = addr_err_q;
  assign frame_err = frame_err_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs[k*DATA_W +: DATA_W] = regs_q[k];
  end

endmodule

// File: tb/tb_spi_regfile_rw.sv
// -----------------------------------------------------------------------------
// tb_spi_regfile_rw
//   Bench for spi_regfile_rw. It builds two instances:
//     A: CPOL=0, NUM_REGS=5, DATA_W=8
//     B: CPOL=1, NUM_REGS=8, DATA_W=16
//   A frame-level reference model predicts register contents, read data and
//   the number of clk cycles each pulse output is high.
// -----------------------------------------------------------------------------
module tb_spi_regfile_rw;

  localparam int AW   = 7;
  localparam int NR_A = 5;
  localparam int DW_A = 8;
  localparam int NR_B = 8;
  localparam int DW_B = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 sclk_a = 1'b0, ncs_a = 1'b1, copi_a = 1'b0;
  logic                 cipo_a, cipo_oe_a, wr_stb_a, addr_err_a, frame_err_a;
  logic [NR_A*DW_A-1:0] regs_a;
  logic [AW-1:0]        wr_addr_a;

  logic                 sclk_b = 1'b1, ncs_b = 1'b1, copi_b = 1'b0;
  logic                 cipo_b, cipo_oe_b, wr_stb_b, addr_err_b, frame_err_b;
  logic [NR_B*DW_B-1:0] regs_b;
  logic [AW-1:0]        wr_addr_b;

  spi_regfile_rw #(.NUM_REGS(NR_A), .DATA_W(DW_A), .ADDR_W(AW), .SYNC_STAGES(2), .CPOL(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .sclk(sclk_a), .ncs(ncs_a), .copi(copi_a),
    .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs(regs_a), .wr_stb(wr_stb_a),
    .wr_addr(wr_addr_a), .addr_err(addr_err_a), .frame_err(frame_err_a)
  );

  spi_regfile_rw #(.NUM_REGS(NR_B), .DATA_W(DW_B), .ADDR_W(AW), .SYNC_STAGES(2), .CPOL(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .sclk(sclk_b), .ncs(ncs_b), .copi(copi_b),
    .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs(regs_b), .wr_stb(wr_stb_b),
    .wr_addr(wr_addr_b), .addr_err(addr_err_b), .frame_err(frame_err_b)
  );

  int tests = 0;
  int fails = 0;

  // Pulse monitors: count the clk cycles each pulse output is high.
  int            n_wr [2];
  int            n_ae [2];
  int            n_fe [2];
  logic [AW-1:0] last_wa [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_wr[i] = 0; n_ae[i] = 0; n_fe[i] = 0; last_wa[i] = '0;
    end
  end

  always @(negedge clk) begin
    if (wr_stb_a)    begin n_wr[0]++; last_wa[0] = wr_addr_a; end
    if (addr_err_a)  n_ae[0]++;
    if (frame_err_a) n_fe[0]++;
    if (wr_stb_b)    begin n_wr[1]++; last_wa[1] = wr_addr_b; end
    if (addr_err_b)  n_ae[1]++;
    if (frame_err_b) n_fe[1]++;
  end

  // Reference register contents.
  logic [DW_A-1:0] ma [NR_A];
  logic [DW_B-1:0] mb [NR_B];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_regs(input int d);
    logic [127:0] r = '0;
    if (d == 0) for (int k = 0; k < NR_A; k++) r[k*DW_A +: DW_A] = ma[k];
    else        for (int k = 0; k < NR_B; k++) r[k*DW_B +: DW_B] = mb[k];
    return r;
  endfunction

  function automatic logic [127:0] dut_regs(input int d);
    return (d == 0) ? 128'(regs_a) : 128'(regs_b);
  endfunction

  function automatic logic get_cipo(input int d);
    return (d == 0) ? cipo_a : cipo_b;
  endfunction

  function automatic logic get_oe(input int d);
    return (d == 0) ? cipo_oe_a : cipo_oe_b;
  endfunction

  task automatic set_pins(input int d, input logic s, input logic n, input logic c);
    if (d == 0) begin sclk_a = s; ncs_a = n; copi_a = c; end
    else        begin sclk_b = s; ncs_b = n; copi_b = c; end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Controller model. It clocks nbits frame bits (MSB first) plus 'extra'
  // zero bits. sclk has a half period of 6 clk. cipo is captured just before
  // each leading edge of the data phase, which is where a real controller
  // samples it.
  task automatic spi_frame(input int d, input logic [31:0] frame, input int fw,
                           input int nbits, input int extra, input bit do_fall,
                           input bit do_rise, output logic [31:0] rd, output logic oe_mid);
    logic idle;
    logic c;
    int   dw;
    idle = (d == 1);
    dw   = fw - 1 - AW;
    rd   = '0;
    if (do_fall) set_pins(d, idle, 1'b0, 1'b0);
    wait_clk(8);
    oe_mid = get_oe(d);
    for (int i = 0; i < nbits + extra; i++) begin
      c = (i < nbits) ? frame[fw-1-i] : 1'b0;
      set_pins(d, idle, 1'b0, c);
      wait_clk(6);
      if (i >= AW + 1 && i < AW + 1 + dw) rd = {rd[30:0], get_cipo(d)};
      set_pins(d, ~idle, 1'b0, c);
      wait_clk(6);
    end
    set_pins(d, idle, 1'b0, 1'b0);
    wait_clk(8);
    if (do_rise) begin
      set_pins(d, idle, 1'b1, 1'b0);
      wait_clk(8);
    end
  endtask

  // Runs one frame and checks the DUT against the frame-level rules.
  task automatic do_frame(input int d, input bit rw, input int addr, input logic [15:0] data,
                          input int nbits, input int extra, input string tag);
    int          nr, dw, fw, wr0, ae0, fe0;
    logic [31:0] frame, rd, exp_rd;
    logic        oe_mid, full, ok, exp_wr;
    nr    = (d == 0) ? NR_A : NR_B;
    dw    = (d == 0) ? DW_A : DW_B;
    fw    = 1 + AW + dw;
    frame = (32'(rw) << (AW + dw)) | (32'(7'(addr)) << dw) | (32'(data) & ((32'd1 << dw) - 1));
    wr0 = n_wr[d]; ae0 = n_ae[d]; fe0 = n_fe[d];
    spi_frame(d, frame, fw, nbits, extra, 1'b1, 1'b1, rd, oe_mid);
    full   = (nbits >= fw);
    ok     = (addr < nr);
    exp_wr = full && rw && ok;
    exp_rd = '0;
    if (ok) exp_rd = (d == 0) ? 32'(ma[addr]) : 32'(mb[addr]);
    if (exp_wr) begin
      if (d == 0) ma[addr] = data[DW_A-1:0];
      else        mb[addr] = data;
    end
    check({tag, " regs"}, dut_regs(d), model_regs(d));
    check({tag, " wr_stb cycles"}, 128'(n_wr[d] - wr0), 128'(exp_wr ? 1 : 0));
    check({tag, " addr_err cycles"}, 128'(n_ae[d] - ae0), 128'((full && !ok) ? 1 : 0));
    check({tag, " frame_err cycles"}, 128'(n_fe[d] - fe0), 128'(full ? 0 : 1));
    check({tag, " cipo_oe selected"}, 128'(oe_mid), 128'(1));
    check({tag, " cipo_oe deselected"}, 128'(get_oe(d)), 128'(0));
    check({tag, " cipo idle"}, 128'(get_cipo(d)), 128'(0));
    if (exp_wr) check({tag, " wr_addr"}, 128'(last_wa[d]), 128'(7'(addr)));
    if (full && !rw) check({tag, " read data"}, 128'(rd), 128'(exp_rd));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " regs_a"}, 128'(regs_a), 128'(0));
    check({tag, " regs_b"}, 128'(regs_b), 128'(0));
    check({tag, " cipo/oe/pulses a"}, 128'({cipo_a, cipo_oe_a, wr_stb_a, addr_err_a, frame_err_a}), 128'(0));
    check({tag, " cipo/oe/pulses b"}, 128'({cipo_b, cipo_oe_b, wr_stb_b, addr_err_b, frame_err_b}), 128'(0));
    check({tag, " wr_addr a"}, 128'(wr_addr_a), 128'(0));
    check({tag, " wr_addr b"}, 128'(wr_addr_b), 128'(0));
  endtask

  initial begin
    logic [31:0] rd;
    logic        oe_mid;
    int          wr0;
    int          d, nr, dw, fw, nbits, extra, kind;

    for (int k = 0; k < NR_A; k++) ma[k] = '0;
    for (int k = 0; k < NR_B; k++) mb[k] = '0;

    // Reset state.
    rst = 1'b1;
    wait_clk(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(6);

    // 1: write addr 0 = 0xA5, then read it back.
    do_frame(0, 1'b1, 0, 16'h00A5, 16, 0, "t1 write");
    do_frame(0, 1'b0, 0, 16'h0000, 16, 0, "t1 read");

    // 2: write addr 4, then write the missing addr 5.
    do_frame(0, 1'b1, 4, 16'h003C, 16, 0, "t2 write4");
    do_frame(0, 1'b1, 5, 16'h00FF, 16, 0, "t2 write5");

    // 3: short write to addr 1 (8 + 5 bits), then a full frame.
    do_frame(0, 1'b1, 1, 16'h00B8, 13, 0, "t3 short");
    do_frame(0, 1'b1, 1, 16'h005A, 16, 0, "t3 full");

    // 4: write addr 2 followed by 8 extra sclk pulses.
    do_frame(0, 1'b1, 2, 16'h0011, 16, 8, "t4 extra");

    // 5: reset after 10 bits of a write to addr 3, with ncs held low.
    spi_frame(0, 32'h0000_8377, 16, 10, 0, 1'b1, 1'b0, rd, oe_mid);
    rst = 1'b1;
    wait_clk(2);
    check_reset_outputs("t5 reset");
    for (int k = 0; k < NR_A; k++) ma[k] = '0;
    for (int k = 0; k < NR_B; k++) mb[k] = '0;
    rst = 1'b0;
    wr0 = n_wr[0];
    spi_frame(0, 32'h0000_8377, 16, 6, 0, 1'b0, 1'b1, rd, oe_mid);
    check("t5 no write regs", 128'(regs_a), model_regs(0));
    check("t5 no wr_stb", 128'(n_wr[0] - wr0), 128'(0));
    do_frame(0, 1'b1, 3, 16'h0077, 16, 0, "t5 after");

    // 6: CPOL=1, 16-bit instance.
    do_frame(1, 1'b1, 7, 16'hBEEF, 24, 0, "t6 write7");
    do_frame(1, 1'b0, 7, 16'h0000, 24, 0, "t6 read7");
    do_frame(1, 1'b0, 8, 16'h0000, 24, 0, "t6 read8");

    // Randomised frames on both instances: mostly complete frames, some
    // short frames and some with trailing extra clocks.
    for (int i = 0; i < 50; i++) begin
      d     = (i < 30) ? 0 : 1;
      nr    = (d == 0) ? NR_A : NR_B;
      dw    = (d == 0) ? DW_A : DW_B;
      fw    = 1 + AW + dw;
      kind  = $urandom_range(0, 9);
      nbits = (kind == 0) ? $urandom_range(0, fw - 1) : fw;
      extra = (kind == 1) ? $urandom_range(1, 8) : 0;
      do_frame(d, 1'($urandom_range(0, 1)), $urandom_range(0, nr + 2),
               16'($urandom), nbits, extra, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
